univ_shift_reg: RTL



---
 rtl/usr_pkg.sv | 30 +++
 rtl/usr_next_val.sv | 30 +++
 rtl/univ_shift_reg.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operating modes,
// sequencer states and the raw 3-bit mode encodings used when driving i_mode.
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'd0,
        MODE_LOAD = 3'd1,
        MODE_SHL  = 3'd2,
        MODE_SHR  = 3'd3,
        MODE_ROL  = 3'd4,
        MODE_ROR  = 3'd5,
        MODE_SHLN = 3'd6,
        MODE_RSVD = 3'd7
    } mode_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_SHIFTING = 1'b1
    } state_e;

    localparam logic [2:0] MODE_ENC_HOLD = 3'd0;
    localparam logic [2:0] MODE_ENC_LOAD = 3'd1;
    localparam logic [2:0] MODE_ENC_SHL  = 3'd2;
    localparam logic [2:0] MODE_ENC_SHR  = 3'd3;
    localparam logic [2:0] MODE_ENC_ROL  = 3'd4;
    localparam logic [2:0] MODE_ENC_ROR  = 3'd5;
    localparam logic [2:0] MODE_ENC_SHLN = 3'd6;
    localparam logic [2:0] MODE_ENC_RSVD = 3'd7;

endpackage

// File: rtl/usr_next_val.sv
// Combinational next-value datapath for the universal shift register.
// The caller resolves enable, sequencing and clear; this block only applies
// the effective single-step operation to the current contents.
module usr_next_val
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_sin_l,
    input  logic             i_sin_r,
    input  mode_e            i_mode,
    output logic [WIDTH-1:0] o_q_next
);

    // Select the next register value for the effective mode; anything else holds.
    always_comb begin
        o_q_next = i_q;
        case (i_mode)
            MODE_LOAD: o_q_next = i_d;
            MODE_SHL:  o_q_next = {i_q[WIDTH-2:0], i_sin_l};
            MODE_SHR:  o_q_next = {i_sin_r, i_q[WIDTH-1:1]};
            MODE_ROL:  o_q_next = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
            MODE_ROR:  o_q_next = {i_q[0], i_q[WIDTH-1:1]};
            default:   o_q_next = i_q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: hold, load, shift/rotate left/right and a
// multi-cycle shift-left-by-N sequence with busy/done handshake.
// Optional even-parity output enabled by defining UNIV_SHIFT_REG_PARITY_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | accepting single-cycle ops; a SHLN start does its 1st shift
// ST_SHIFTING | SHLN in progress, one SHL per clock, En/Mode/D/Amt ignored
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    parameter int                 AMT_W     = 3
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_en,
    input  logic             i_sclr,
    input  logic [2:0]       i_mode,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_sin_l,
    input  logic             i_sin_r,
    input  logic [AMT_W-1:0] i_amt,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_qbar,
    output logic             o_sout_l,
    output logic             o_sout_r,
    output logic             o_busy,
    output logic             o_done
`ifdef UNIV_SHIFT_REG_PARITY_EN
    ,
    output logic             o_par
`endif
);

    logic [WIDTH-1:0] r_q;
    state_e           r_state;
    logic [AMT_W-1:0] r_cnt;
    logic             r_done;

    state_e           w_state_next;
    logic [AMT_W-1:0] w_cnt_next;
    logic             w_done_next;
    mode_e            w_mode_eff;
    logic [WIDTH-1:0] w_q_step;
    logic [WIDTH-1:0] w_q_next;

    // r_cnt holds the shifts still to go after the current edge, so the start
    // edge stores Amt-1 and the sequence ends on the edge that sees r_cnt==1.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        w_mode_eff   = MODE_HOLD;
        if (i_sclr) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_en) begin
                        case (mode_e'(i_mode))
                            MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR:
                                w_mode_eff = mode_e'(i_mode);
                            MODE_SHLN: begin
                                if (i_amt != '0) begin
                                    w_mode_eff = MODE_SHL;
                                    w_cnt_next = i_amt - AMT_W'(1);
                                    if (i_amt == AMT_W'(1)) begin
                                        w_done_next = 1'b1;
                                    end else begin
                                        w_state_next = ST_SHIFTING;
                                    end
                                end
                            end
                            default: w_mode_eff = MODE_HOLD;
                        endcase
                    end
                end
                ST_SHIFTING: begin
                    w_mode_eff = MODE_SHL;
                    w_cnt_next = r_cnt - AMT_W'(1);
                    if (r_cnt == AMT_W'(1)) begin
                        w_done_next  = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    usr_next_val #(
        .WIDTH (WIDTH)
    ) u_next_val (
        .i_q      (r_q),
        .i_d      (i_d),
        .i_sin_l  (i_sin_l),
        .i_sin_r  (i_sin_r),
        .i_mode   (w_mode_eff),
        .o_q_next (w_q_step)
    );

    assign w_q_next = i_sclr ? RESET_VAL : w_q_step;

    // Sequencer state, remaining count and done pulse.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
        end
    end

    // Register contents.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= w_q_next;
        end
    end

`ifdef UNIV_SHIFT_REG_PARITY_EN
    logic r_par;

    // Parity is computed from the next value so it never lags Q.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_par <= ^RESET_VAL;
        end else begin
            r_par <= ^w_q_next;
        end
    end

    assign o_par = r_par;
`endif

    assign o_q      = r_q;
    assign o_qbar   = ~r_q;
    assign o_sout_l = r_q[WIDTH-1];
    assign o_sout_r = r_q[0];
    assign o_busy   = (r_state == ST_SHIFTING);
    assign o_done   = r_done;

endmodule
